// File: rtl/logfbe_pkg.sv
// logfbe_pkg: shared FSM encoding and frame geometry for the log-FBE buffer path
package logfbe_pkg;
    localparam int LOGFBE_NUM_CH = 26;
    localparam int LOGFBE_DW = 16;
    typedef enum logic [1:0] {IDLE, DRAIN, WAIT_LAST} state_t;
endpackage

// File: rtl/logfbe_skid_buf.sv
// logfbe_skid_buf: 2-entry registered valid/ready buffer exporting its occupancy
module logfbe_skid_buf #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_payload,
    output logic [1:0]   occ
);
    logic [W-1:0] h, s;
    logic pop;
    assign m_valid = occ != 2'd0;
    assign pop = m_valid & m_ready;
    assign m_payload = h;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            s <= '0;
            occ <= 2'd0;
        end else begin
            if (pop) begin
                h <= (occ == 2'd2) ? s : wr_data;
                if (wr_en && occ == 2'd2) s <= wr_data;
            end else if (wr_en) begin
                if (occ == 2'd0) h <= wr_data;
                else s <= wr_data;
            end
            occ <= occ + {1'b0, wr_en} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/logfbe_frame_reader.sv
// logfbe_frame_reader: pops one whole frame from the log-FBE FIFO and streams it
// with channel index and last flag, absorbing downstream back-pressure.
module logfbe_frame_reader
    import logfbe_pkg::*;
#(
    parameter int DATA_WIDTH = LOGFBE_DW,
    parameter int NUM_CH     = LOGFBE_NUM_CH,
    parameter int IDX_WIDTH  = 5,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_full,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [IDX_WIDTH-1:0]  m_idx,
    output logic                  m_last,
    output logic                  frame_done,
    output logic                  err_underflow
);
    localparam int CW = IDX_WIDTH + 1;
    localparam int W = DATA_WIDTH + IDX_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(NUM_CH);
    localparam logic [CW-1:0] LASTC = CW'(NUM_CH - 1);
    state_t state, state_nxt;
    logic [CW-1:0] pop_cnt, out_cnt, wr_idx;
    logic [1:0] occ, occ_left;
    logic in_flight, hs, credit, want, wr_en;
    logic [W-1:0] payload;
    assign hs = m_valid & m_ready;
    assign frame_done = hs & m_last;
    // Credit counts the head beat leaving this cycle so a full-rate stream keeps popping.
    assign occ_left = occ - {1'b0, hs};
    assign credit = (3'(occ_left) + 3'(in_flight)) < 3'd2;
    assign wr_en = (RD_LATENCY == 0) ? fifo_rd_en : in_flight;
    assign wr_idx = out_cnt + CW'(occ);
    always_comb begin
        state_nxt = state;
        want = 1'b0;
        case (state)
            IDLE: state_nxt = fifo_almost_full ? DRAIN : IDLE;
            DRAIN: begin
                want = (pop_cnt < FULL) && credit;
                state_nxt = (want && !fifo_empty && pop_cnt == LASTC) ? WAIT_LAST : DRAIN;
            end
            WAIT_LAST: state_nxt = (hs && m_last) ? IDLE : WAIT_LAST;
            default: state_nxt = IDLE;
        endcase
        fifo_rd_en = want && !fifo_empty;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pop_cnt <= '0;
            out_cnt <= '0;
            in_flight <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) pop_cnt <= '0;
            else if (fifo_rd_en) pop_cnt <= pop_cnt + 1'b1;
            in_flight <= (RD_LATENCY != 0) && fifo_rd_en;
            if (hs) out_cnt <= m_last ? '0 : out_cnt + 1'b1;
            if (want && fifo_empty) err_underflow <= 1'b1;
        end
    end
    logfbe_skid_buf #(.W(W)) u_buf (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data({fifo_rd_data, wr_idx[IDX_WIDTH-1:0], wr_idx == LASTC}),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_payload(payload),
        .occ(occ)
    );
    assign {m_data, m_idx, m_last} = payload;
endmodule

// File: tb/tb_logfbe_frame_reader.sv
// tb_logfbe_frame_reader: frame reader against a behavioural 32x16 sync FIFO and a stream model
module tb_logfbe_frame_reader;
    import logfbe_pkg::*;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    logic fifo_rd_en, fifo_empty, fifo_almost_full, m_valid, m_ready, m_last, frame_done, err_underflow;
    logic [15:0] fifo_rd_data, m_data;
    logic [4:0] m_idx;
    logic wr_en = 0;
    logic [15:0] wr_data = 0;
    logic force_empty = 0;
    logic [15:0] q[$];
    int fcnt = 0;
    int errors = 0, checks = 0;

    logfbe_frame_reader dut (
        .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .fifo_almost_full(fifo_almost_full), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
        .frame_done(frame_done), .err_underflow(err_underflow)
    );

    assign fifo_empty = force_empty | (fcnt == 0);
    assign fifo_almost_full = fcnt >= 26;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            fcnt <= 0;
            fifo_rd_data <= '0;
        end else begin
            if (fifo_rd_en && q.size() > 0) fifo_rd_data <= q.pop_front();
            if (wr_en && q.size() < 32) q.push_back(wr_data);
            fcnt <= q.size();
        end
    end

    logic [15:0] got_d[$];
    logic [4:0] got_i[$];
    logic got_l[$];
    int beat_cyc[$];
    int cyc = 0, pops = 0, acc = 0, max_out = 0, fd_cnt = 0, rd_when_empty = 0, stab_err = 0, wait_cnt = 0;
    logic prev_stall = 0, was_wait = 0;
    logic [22:0] prev = '0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
            was_wait = 0;
            pops = 0;
            acc = 0;
        end else begin
            if (prev_stall && {m_valid, m_data, m_idx, m_last} !== prev) stab_err++;
            prev_stall = m_valid && !m_ready;
            prev = {m_valid, m_data, m_idx, m_last};
            if (fifo_rd_en) pops++;
            if (fifo_rd_en && fifo_empty) rd_when_empty++;
            if (m_valid && m_ready) begin
                acc++;
                got_d.push_back(m_data);
                got_i.push_back(m_idx);
                got_l.push_back(m_last);
                beat_cyc.push_back(cyc);
            end
            if (frame_done) fd_cnt++;
            if (pops - acc > max_out) max_out = pops - acc;
            if (dut.state == WAIT_LAST && !was_wait) wait_cnt++;
            was_wait = (dut.state == WAIT_LAST);
        end
    end

    logic [15:0] exp_d[$];
    int seg_got = 0, seg_exp = 0, done = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input bit rnd, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            logic [15:0] v;
            v = rnd ? 16'($urandom) : base + 16'(i);
            tick();
            wr_en = 1;
            wr_data = v;
            exp_d.push_back(v);
        end
        tick();
        wr_en = 0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int c = 0;
        while (got_d.size() - seg_got < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (got_d.size() - seg_got < n) begin
            errors++;
            $display("FAIL %s timeout: beats=%0d required=%0d", name, got_d.size() - seg_got, n);
        end
    endtask

    task automatic check_beats(input int from, input int n, input string name);
        for (int k = from; k < from + n; k++) begin
            int g;
            logic [15:0] e;
            g = seg_got + k;
            e = exp_d[seg_exp + k];
            checks++;
            if (g >= got_d.size()) begin
                errors++;
                $display("FAIL %s beat %0d missing, required data=%h", name, k, e);
            end else if (got_d[g] !== e || got_i[g] !== 5'(k % 26) || got_l[g] !== (k % 26 == 25)) begin
                errors++;
                $display("FAIL %s beat %0d: got data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                         name, k, got_d[g], got_i[g], got_l[g], e, k % 26, k % 26 == 25);
            end
        end
    endtask

    task automatic test_reset();
        m_ready = 0;
        rst = 1;
        repeat (2) tick();
        checks++; if (fifo_rd_en !== 0) begin errors++; $display("FAIL reset fifo_rd_en got=%b required=0", fifo_rd_en); end
        checks++; if (m_valid !== 0) begin errors++; $display("FAIL reset m_valid got=%b required=0", m_valid); end
        checks++; if (m_data !== 0) begin errors++; $display("FAIL reset m_data got=%h required=0", m_data); end
        checks++; if (m_idx !== 0) begin errors++; $display("FAIL reset m_idx got=%0d required=0", m_idx); end
        checks++; if (m_last !== 0) begin errors++; $display("FAIL reset m_last got=%b required=0", m_last); end
        checks++; if (frame_done !== 0) begin errors++; $display("FAIL reset frame_done got=%b required=0", frame_done); end
        checks++; if (err_underflow !== 0) begin errors++; $display("FAIL reset err_underflow got=%b required=0", err_underflow); end
        rst = 0;
        tick();
    endtask

    task automatic test_single_frame();
        int f0;
        f0 = fd_cnt;
        m_ready = 1;
        push_words(26, 0, 16'h0100);
        wait_beats(done + 26, 300, "single");
        check_beats(done, 26, "single");
        checks++;
        if (got_d.size() >= seg_got + done + 26 &&
            beat_cyc[seg_got + done + 25] - beat_cyc[seg_got + done] !== 25) begin
            errors++;
            $display("FAIL single throughput span got=%0d required=25",
                     beat_cyc[seg_got + done + 25] - beat_cyc[seg_got + done]);
        end
        done += 26;
        repeat (4) tick();
        checks++; if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL single frame_done pulses got=%0d required=1", fd_cnt - f0); end
        checks++; if (fifo_empty !== 1) begin errors++; $display("FAIL single fifo_empty got=%b required=1", fifo_empty); end
    endtask

    task automatic test_partial();
        int p0, b0;
        p0 = pops;
        b0 = got_d.size();
        m_ready = 1;
        push_words(25, 1, 0);
        repeat (20) tick();
        checks++; if (pops - p0 !== 0) begin errors++; $display("FAIL partial pops got=%0d required=0", pops - p0); end
        checks++; if (m_valid !== 0 || got_d.size() !== b0) begin errors++; $display("FAIL partial m_valid got=%b beats=%0d required=0", m_valid, got_d.size() - b0); end
        push_words(1, 1, 0);
        wait_beats(done + 26, 300, "partial");
        check_beats(done, 26, "partial");
        done += 26;
        repeat (4) tick();
    endtask

    task automatic test_backpressure();
        int p0, s0, c;
        p0 = pops;
        s0 = stab_err;
        m_ready = 0;
        push_words(26, 1, 0);
        repeat (30) tick();
        checks++; if (m_valid !== 1) begin errors++; $display("FAIL bp held m_valid got=%b required=1", m_valid); end
        c = 0;
        while (got_d.size() - seg_got < done + 26 && c < 400) begin
            m_ready = (c < 20) ? ~m_ready : 1'($urandom);
            tick();
            c++;
        end
        m_ready = 1;
        wait_beats(done + 26, 50, "bp");
        check_beats(done, 26, "bp");
        done += 26;
        repeat (4) tick();
        checks++; if (stab_err - s0 !== 0) begin errors++; $display("FAIL bp stability violations got=%0d required=0", stab_err - s0); end
        checks++; if (max_out > 2) begin errors++; $display("FAIL bp outstanding got=%0d required<=2", max_out); end
        checks++; if (pops - p0 !== 26) begin errors++; $display("FAIL bp pops got=%0d required=26", pops - p0); end
    endtask

    task automatic test_back_to_back();
        int f0, w0;
        f0 = fd_cnt;
        w0 = wait_cnt;
        m_ready = 1;
        push_words(52, 1, 0);
        wait_beats(done + 52, 500, "b2b");
        check_beats(done, 52, "b2b");
        done += 52;
        repeat (4) tick();
        checks++; if (fd_cnt - f0 !== 2) begin errors++; $display("FAIL b2b frame_done pulses got=%0d required=2", fd_cnt - f0); end
        checks++; if (wait_cnt - w0 !== 2) begin errors++; $display("FAIL b2b WAIT_LAST entries got=%0d required=2", wait_cnt - w0); end
        checks++; if (err_underflow !== 0) begin errors++; $display("FAIL b2b err_underflow got=%b required=0", err_underflow); end
    endtask

    task automatic test_reset_mid();
        m_ready = 1;
        push_words(26, 1, 0);
        wait_beats(done + 10, 300, "rstmid");
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_data, m_idx, m_last, frame_done, err_underflow} !== '0) begin
            errors++;
            $display("FAIL rstmid outputs got rd=%b v=%b d=%h i=%0d l=%b fd=%b e=%b required all 0",
                     fifo_rd_en, m_valid, m_data, m_idx, m_last, frame_done, err_underflow);
        end
        tick();
        rst = 0;
        seg_got = got_d.size();
        seg_exp = exp_d.size();
        done = 0;
        tick();
        push_words(26, 1, 0);
        wait_beats(26, 300, "rstmid_fresh");
        check_beats(0, 26, "rstmid_fresh");
        done = 26;
        repeat (4) tick();
    endtask

    task automatic test_underflow();
        int e0, p0;
        e0 = rd_when_empty;
        m_ready = 1;
        push_words(26, 1, 0);
        wait_beats(done + 5, 300, "uflow");
        tick();
        force_empty = 1;
        p0 = pops;
        repeat (10) tick();
        checks++; if (err_underflow !== 1) begin errors++; $display("FAIL uflow err got=%b required=1", err_underflow); end
        checks++; if (pops - p0 !== 0) begin errors++; $display("FAIL uflow pops while empty got=%0d required=0", pops - p0); end
        force_empty = 0;
        wait_beats(done + 26, 300, "uflow");
        check_beats(done, 26, "uflow");
        done += 26;
        repeat (4) tick();
        checks++; if (err_underflow !== 1) begin errors++; $display("FAIL uflow sticky err got=%b required=1", err_underflow); end
        checks++; if (rd_when_empty - e0 !== 0) begin errors++; $display("FAIL uflow rd_en with empty got=%0d required=0", rd_when_empty - e0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
